useq_prog_loader: RTL and testbench

- Upstream stage of the useq microsequencer: owns the 256x8 program memory that drives useq's mem_addr/mem_data port, and fills it from a byte stream (typically a UART RX).
- Holds the core in reset (cpu_rst_n) while loading, and releases it only after a framed, checksum-verified image has been written.
- Frame format: SYNC, LEN, LEN data bytes, CSUM.

---
 rtl/useq_prog_loader.sv | 132 +++++++++++++
 tb/tb_useq_prog_loader.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/useq_prog_loader.sv
// Program loader for useq: receives a framed byte stream (SYNC, LEN, data, CSUM) into a
// 256x8 program memory and holds the core in reset until a checksum-verified image is in place.
module useq_prog_loader #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter logic [7:0] LOAD_BASE      = 8'h00,
    parameter int         TIMEOUT_CYCLES = 100000,
    parameter int         TO_W           = 17
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready,
    input  logic [7:0] mem_addr,
    output logic [7:0] mem_data,
    output logic       cpu_rst_n,
    output logic       busy,
    output logic       load_ok,
    output logic       load_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_CSUM
    } state_t;

    state_t      state_q;
    logic        rx_ready_q;
    logic        cpu_rst_n_q;
    logic        load_ok_q;
    logic        load_err_q;
    logic [7:0]  wr_addr_q;
    logic [7:0]  sum_q;
    logic [8:0]  rem_q;
    logic [TO_W-1:0] to_q;

    logic [7:0]  mem [256];

    logic        accept;
    logic        mem_we;
    logic        to_expired;
    logic [7:0]  wr_addr_d;
    logic [7:0]  sum_d;
    logic [8:0]  rem_d;

    always_comb begin
        accept     = rx_valid & rx_ready_q;
        mem_we     = accept && (state_q == S_DATA);
        to_expired = (to_q == TO_W'(TIMEOUT_CYCLES - 1));
        wr_addr_d  = wr_addr_q + 8'd1;
        sum_d      = sum_q + rx_data;
        rem_d      = rem_q - 9'd1;
    end

    // Program memory is deliberately not reset; contents survive rst_n.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_addr_q] <= rx_data;
        end
    end

    assign mem_data = mem[mem_addr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rx_ready_q  <= 1'b0;
            cpu_rst_n_q <= 1'b0;
            load_ok_q   <= 1'b0;
            load_err_q  <= 1'b0;
            wr_addr_q   <= 8'h00;
            sum_q       <= 8'h00;
            rem_q       <= 9'd0;
            to_q        <= '0;
        end else begin
            rx_ready_q <= 1'b1;
            if (state_q == S_IDLE) begin
                to_q <= '0;
                if (accept && (rx_data == SYNC_BYTE)) begin
                    state_q     <= S_LEN;
                    cpu_rst_n_q <= 1'b0;
                    load_ok_q   <= 1'b0;
                    load_err_q  <= 1'b0;
                    sum_q       <= 8'h00;
                    wr_addr_q   <= LOAD_BASE;
                end
            end else if (accept) begin
                to_q <= '0;
                case (state_q)
                    S_LEN: begin
                        // A zero length field encodes a full 256-byte image.
                        rem_q   <= (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
                        state_q <= S_DATA;
                    end
                    S_DATA: begin
                        wr_addr_q <= wr_addr_d;
                        sum_q     <= sum_d;
                        rem_q     <= rem_d;
                        if (rem_q == 9'd1) begin
                            state_q <= S_CSUM;
                        end
                    end
                    S_CSUM: begin
                        state_q <= S_IDLE;
                        if (rx_data == sum_q) begin
                            load_ok_q   <= 1'b1;
                            cpu_rst_n_q <= 1'b1;
                        end else begin
                            load_err_q  <= 1'b1;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end else if (to_expired) begin
                state_q    <= S_IDLE;
                load_err_q <= 1'b1;
                to_q       <= '0;
            end else begin
                to_q <= to_q + 1'b1;
            end
        end
    end

    assign rx_ready  = rx_ready_q;
    assign cpu_rst_n = cpu_rst_n_q;
    assign load_ok   = load_ok_q;
    assign load_err  = load_err_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_useq_prog_loader.sv
// Directed bench for useq_prog_loader: one instance at base 00, one at base FE, both with a
// short timeout, fed from the same byte stream.
module tb_useq_prog_loader;

    logic       clk;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] mem_addr;

    logic       rx_ready, cpu_rst_n, busy, load_ok, load_err;
    logic [7:0] mem_data;
    logic       rx_ready_fe, cpu_rst_n_fe, busy_fe, load_ok_fe, load_err_fe;
    logic [7:0] mem_data_fe;

    int checks   = 0;
    int failures = 0;

    useq_prog_loader #(
        .SYNC_BYTE(8'hA5), .LOAD_BASE(8'h00), .TIMEOUT_CYCLES(20), .TO_W(5)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .mem_addr(mem_addr), .mem_data(mem_data),
        .cpu_rst_n(cpu_rst_n), .busy(busy), .load_ok(load_ok), .load_err(load_err)
    );

    useq_prog_loader #(
        .SYNC_BYTE(8'hA5), .LOAD_BASE(8'hFE), .TIMEOUT_CYCLES(20), .TO_W(5)
    ) u_dut_fe (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready_fe), .mem_addr(mem_addr), .mem_data(mem_data_fe),
        .cpu_rst_n(cpu_rst_n_fe), .busy(busy_fe), .load_ok(load_ok_fe), .load_err(load_err_fe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present a byte for exactly one clock (back-to-back calls stream without gaps).
    task automatic put(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rx_valid = 1'b0;
            rx_data  = 8'h00;
        end
    endtask

    task automatic rd(input string tag, input logic [7:0] a, input logic [7:0] exp);
        mem_addr = a;
        #1;
        chk(tag, {24'd0, mem_data}, {24'd0, exp});
    endtask

    task automatic rd_fe(input string tag, input logic [7:0] a, input logic [7:0] exp);
        mem_addr = a;
        #1;
        chk(tag, {24'd0, mem_data_fe}, {24'd0, exp});
    endtask

    initial begin
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        mem_addr = 8'h00;
        #12;
        chk("rst_rx_ready",  {31'd0, rx_ready},  32'd0);
        chk("rst_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
        chk("rst_busy",      {31'd0, busy},      32'd0);
        chk("rst_load_ok",   {31'd0, load_ok},   32'd0);
        chk("rst_load_err",  {31'd0, load_err},  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        chk("rx_ready_up", {31'd0, rx_ready}, 32'd1);

        // Good 4-byte frame: 11+22+33+44 = AA.
        put(8'hA5); put(8'h04); put(8'h11); put(8'h22); put(8'h33); put(8'h44);
        chk("t1_busy_loading", {31'd0, busy},      32'd1);
        put(8'hAA);
        chk("t1_core_held",    {31'd0, cpu_rst_n}, 32'd0);
        idle(1);
        chk("t1_load_ok",   {31'd0, load_ok},   32'd1);
        chk("t1_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd1);
        chk("t1_busy",      {31'd0, busy},      32'd0);
        rd("t1_mem00", 8'h00, 8'h11);
        rd("t1_mem01", 8'h01, 8'h22);
        rd("t1_mem02", 8'h02, 8'h33);
        rd("t1_mem03", 8'h03, 8'h44);

        // Bad checksum: expected 03, sent FF.
        put(8'hA5); put(8'h02); put(8'h01); put(8'h02); put(8'hFF);
        idle(1);
        chk("t2_load_err",  {31'd0, load_err},  32'd1);
        chk("t2_load_ok",   {31'd0, load_ok},   32'd0);
        chk("t2_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
        rd("t2_mem00", 8'h00, 8'h01);
        rd("t2_mem01", 8'h01, 8'h02);
        rd("t2_mem02_kept", 8'h02, 8'h33);

        // Junk in IDLE is discarded without status change; A5 as data and checksum.
        put(8'h00); put(8'h7E);
        idle(1);
        chk("t3_junk_busy", {31'd0, busy},     32'd0);
        chk("t3_junk_err",  {31'd0, load_err}, 32'd1);
        put(8'hA5); put(8'h01); put(8'hA5); put(8'hA5);
        idle(1);
        chk("t3_load_ok",  {31'd0, load_ok},  32'd1);
        chk("t3_load_err", {31'd0, load_err}, 32'd0);
        rd("t3_mem00", 8'h00, 8'hA5);

        // Address wrap on the FE-based instance: 01+02+03 = 06.
        put(8'hA5); put(8'h03); put(8'h01); put(8'h02); put(8'h03); put(8'h06);
        idle(1);
        chk("t4_load_ok_fe", {31'd0, load_ok_fe}, 32'd1);
        rd_fe("t4_memFE", 8'hFE, 8'h01);
        rd_fe("t4_memFF", 8'hFF, 8'h02);
        rd_fe("t4_mem00", 8'h00, 8'h03);

        // Timeout mid-DATA, then recovery with a good frame.
        put(8'hA5); put(8'h05); put(8'h01);
        idle(10);
        chk("t5_still_busy", {31'd0, busy},     32'd1);
        chk("t5_no_err_yet", {31'd0, load_err}, 32'd0);
        idle(12);
        chk("t5_to_err",     {31'd0, load_err},  32'd1);
        chk("t5_to_idle",    {31'd0, busy},      32'd0);
        chk("t5_to_cpu",     {31'd0, cpu_rst_n}, 32'd0);
        put(8'hA5); put(8'h01); put(8'h5A); put(8'h5A);
        idle(1);
        chk("t5_recover_ok",  {31'd0, load_ok},  32'd1);
        chk("t5_recover_err", {31'd0, load_err}, 32'd0);
        chk("t5_recover_cpu", {31'd0, cpu_rst_n}, 32'd1);

        // SYNC while the core runs re-enters load and drops the core reset.
        put(8'hA5);
        idle(1);
        chk("t6_cpu_drop", {31'd0, cpu_rst_n}, 32'd0);
        chk("t6_ok_clear", {31'd0, load_ok},   32'd0);
        chk("t6_busy",     {31'd0, busy},      32'd1);

        // Length 00 = 256 bytes of i; sum of 0..255 mod 256 = 80.
        put(8'h00);
        for (int i = 0; i < 256; i++) put(8'(i));
        put(8'h80);
        idle(1);
        chk("t7_load_ok", {31'd0, load_ok},   32'd1);
        chk("t7_cpu",     {31'd0, cpu_rst_n}, 32'd1);
        rd("t7_mem00", 8'h00, 8'h00);
        rd("t7_mem5A", 8'h5A, 8'h5A);
        rd("t7_mem80", 8'h80, 8'h80);
        rd("t7_memFF", 8'hFF, 8'hFF);

        // Reset mid-frame: immediate IDLE, partial image retained.
        put(8'hA5); put(8'h02); put(8'h77);
        idle(1);
        rst_n = 1'b0;
        #1;
        chk("t8_rst_busy", {31'd0, busy},      32'd0);
        chk("t8_rst_cpu",  {31'd0, cpu_rst_n}, 32'd0);
        chk("t8_rst_ok",   {31'd0, load_ok},   32'd0);
        rd("t8_mem_kept", 8'h00, 8'h77);
        idle(2);
        rst_n = 1'b1;
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
